// File: rtl/axi_addr_arb_pkg.sv
// Shared types and helpers for the 3:1 AXI address-channel arbiter.
package axi_arb_pkg;

    localparam int unsigned NUM_CH = 3;
    localparam int unsigned IDX_W  = 2;

    typedef enum logic [1:0] {
        ARB_FIXED = 2'd0,
        ARB_RR    = 2'd1,
        ARB_WRR   = 2'd2,
        ARB_RSVD  = 2'd3
    } arb_mode_e;

    typedef logic [IDX_W-1:0] ch_idx_t;

    // Round-robin successor: 0 -> 1 -> 2 -> 0.
    function automatic ch_idx_t next_idx(ch_idx_t idx);
        return (idx >= ch_idx_t'(NUM_CH - 1)) ? ch_idx_t'(0) : idx + ch_idx_t'(1);
    endfunction

endpackage

// File: rtl/axi_addr_arb_if.sv
// Address-channel bundle: three upstream requesters and one downstream port.
interface axi_addr_arb_if #(
    parameter int unsigned PLD_W = 64
);
    import axi_arb_pkg::*;

    logic [NUM_CH-1:0] s_valid;
    logic [NUM_CH-1:0] s_ready;
    logic [PLD_W-1:0]  s_pld0;
    logic [PLD_W-1:0]  s_pld1;
    logic [PLD_W-1:0]  s_pld2;
    logic              m_valid;
    logic              m_ready;
    logic [PLD_W-1:0]  m_pld;
    ch_idx_t           m_src;

    // Arbiter side.
    modport slave (
        input  s_valid, s_pld0, s_pld1, s_pld2, m_ready,
        output s_ready, m_valid, m_pld, m_src
    );

    // Requester/consumer side.
    modport master (
        output s_valid, s_pld0, s_pld1, s_pld2, m_ready,
        input  s_ready, m_valid, m_pld, m_src
    );

endinterface

// File: rtl/axi_addr_arb_pick.sv
// Combinational rotate-priority picker: first set bit of req_i scanning from start_i.
module axi_arb_pick
    import axi_arb_pkg::*;
(
    input  logic [NUM_CH-1:0] req_i,
    input  ch_idx_t           start_i,
    output ch_idx_t           win_o,
    output logic              any_o
);

    ch_idx_t idx_c;
    logic    found_c;

    always_comb begin
        win_o   = start_i;
        found_c = 1'b0;
        idx_c   = start_i;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (!found_c && req_i[idx_c]) begin
                win_o   = idx_c;
                found_c = 1'b1;
            end
            idx_c = next_idx(idx_c);
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/axi_addr_arb.sv
// 3:1 AXI address-channel arbiter (fixed / round-robin / weighted RR) with a 1-entry output register.
// Optional per-channel grant counters when AXI_ARB_STATS_EN is defined.
module axi_addr_arb
    import axi_arb_pkg::*;
#(
    parameter int unsigned PLD_W = 64,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             arb_en,
    input  logic [1:0]       arb_mode,
    input  logic [CNT_W-1:0] weight0,
    input  logic [CNT_W-1:0] weight1,
    input  logic [CNT_W-1:0] weight2,
`ifdef AXI_ARB_STATS_EN
    input  logic             stats_clr,
    output logic [31:0]      gnt_cnt0,
    output logic [31:0]      gnt_cnt1,
    output logic [31:0]      gnt_cnt2,
`endif
    axi_addr_arb_if.slave    bus
);

    arb_mode_e         mode;
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] owner_mask;
    logic [NUM_CH-1:0] ready_c;
    logic [CNT_W-1:0]  owner_weight;
    logic [CNT_W-1:0]  owner_limit;
    logic [PLD_W-1:0]  win_pld;
    ch_idx_t           pick_start;
    ch_idx_t           pick_win;
    ch_idx_t           win;
    logic              pick_any;
    logic              owner_keep;
    logic              load;
    logic              grant;

    logic              m_valid_q, m_valid_d;
    logic [PLD_W-1:0]  m_pld_q,   m_pld_d;
    ch_idx_t           m_src_q,   m_src_d;
    ch_idx_t           last_q,    last_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;

    assign mode = arb_mode_e'(arb_mode);
    assign req  = arb_en ? bus.s_valid : {{(NUM_CH-1){1'b0}}, bus.s_valid[0]};
    assign load = ~m_valid_q | bus.m_ready;

    always_comb begin
        case (last_q)
            ch_idx_t'(0): owner_weight = weight0;
            ch_idx_t'(1): owner_weight = weight1;
            default:      owner_weight = weight2;
        endcase
    end

    // A zero weight still grants once per turn; cnt_q == 0 means nobody owns the grant yet.
    assign owner_limit = (owner_weight == '0) ? CNT_W'(1) : owner_weight;
    assign owner_mask  = NUM_CH'(1) << last_q;
    assign owner_keep  = (mode == ARB_WRR) && |(req & owner_mask)
                         && (cnt_q != '0) && (cnt_q < owner_limit);

    assign pick_start = (mode == ARB_RR || mode == ARB_WRR) ? next_idx(last_q) : ch_idx_t'(0);

    axi_arb_pick u_pick (
        .req_i   (req),
        .start_i (pick_start),
        .win_o   (pick_win),
        .any_o   (pick_any)
    );

    assign win     = owner_keep ? last_q : pick_win;
    assign grant   = rst_n & load & pick_any;
    assign ready_c = grant ? (NUM_CH'(1) << win) : '0;

    always_comb begin
        case (win)
            ch_idx_t'(0): win_pld = bus.s_pld0;
            ch_idx_t'(1): win_pld = bus.s_pld1;
            default:      win_pld = bus.s_pld2;
        endcase
    end

    always_comb begin
        m_valid_d = m_valid_q;
        m_pld_d   = m_pld_q;
        m_src_d   = m_src_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        if (load) begin
            m_valid_d = pick_any;
        end
        if (grant) begin
            m_pld_d = win_pld;
            m_src_d = win;
            last_d  = win;
            // Consecutive-grant count saturates; a handover (or WRR limit hit) restarts at 1.
            if (owner_keep || (mode != ARB_WRR && win == last_q)) begin
                cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
            end else begin
                cnt_d = CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            m_pld_q   <= '0;
            m_src_q   <= ch_idx_t'(0);
            last_q    <= ch_idx_t'(2);
            cnt_q     <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_pld_q   <= m_pld_d;
            m_src_q   <= m_src_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.s_ready = ready_c;
    assign bus.m_valid = m_valid_q;
    assign bus.m_pld   = m_pld_q;
    assign bus.m_src   = m_src_q;

`ifdef AXI_ARB_STATS_EN
    localparam int unsigned STAT_W = 32;

    logic [STAT_W-1:0] gnt_cnt_q [NUM_CH];

    // Clear has priority over a coincident grant.
    always_ff @(posedge clk) begin
        if (!rst_n || stats_clr) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                gnt_cnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (bus.s_valid[i] && ready_c[i]) begin
                    gnt_cnt_q[i] <= gnt_cnt_q[i] + STAT_W'(1);
                end
            end
        end
    end

    assign gnt_cnt0 = gnt_cnt_q[0];
    assign gnt_cnt1 = gnt_cnt_q[1];
    assign gnt_cnt2 = gnt_cnt_q[2];
`endif

endmodule

// File: tb/tb_axi_addr_arb.sv
// Bench for axi_addr_arb: directed vector table, then randomized traffic against a reference model.
module tb_axi_addr_arb;
    import axi_arb_pkg::*;

    localparam int unsigned PLD_W = 64;
    localparam int unsigned CNT_W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             arb_en;
    logic [1:0]       arb_mode;
    logic [CNT_W-1:0] weight0, weight1, weight2;
`ifdef AXI_ARB_STATS_EN
    logic             stats_clr;
    logic [31:0]      gnt_cnt0, gnt_cnt1, gnt_cnt2;
`endif

    axi_addr_arb_if #(.PLD_W(PLD_W)) bus ();

    axi_addr_arb #(.PLD_W(PLD_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .arb_en    (arb_en),
        .arb_mode  (arb_mode),
        .weight0   (weight0),
        .weight1   (weight1),
        .weight2   (weight2),
`ifdef AXI_ARB_STATS_EN
        .stats_clr (stats_clr),
        .gnt_cnt0  (gnt_cnt0),
        .gnt_cnt1  (gnt_cnt1),
        .gnt_cnt2  (gnt_cnt2),
`endif
        .bus       (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: arbitration decisions computed from the rules, kept as plain integers.
    int          m_last, m_cnt, mdl_src;
    logic        mdl_mv;
    logic [63:0] mdl_pld;
    logic [31:0] mdl_g [3];
    logic        g_s, keep_s;
    int          w_s;

    function automatic int weight_of(int c);
        if (c == 0) return int'(weight0);
        if (c == 1) return int'(weight1);
        return int'(weight2);
    endfunction

    function automatic logic [63:0] pld_of(int c);
        if (c == 0) return bus.s_pld0;
        if (c == 1) return bus.s_pld1;
        return bus.s_pld2;
    endfunction

    task automatic model_decide();
        logic [2:0] rq;
        int lim, start, c;
        bit found;
        rq = arb_en ? bus.s_valid : {2'b00, bus.s_valid[0]};
        g_s = 1'b0; keep_s = 1'b0; w_s = 0; found = 1'b0;
        if (rst_n && (!mdl_mv || bus.m_ready) && rq != 3'b000) begin
            g_s = 1'b1;
            if (arb_mode == 2'd2) begin
                lim = weight_of(m_last);
                if (lim == 0) lim = 1;
                if (rq[m_last] && m_cnt != 0 && m_cnt < lim) begin
                    keep_s = 1'b1; w_s = m_last; found = 1'b1;
                end
            end
            start = (arb_mode == 2'd1 || arb_mode == 2'd2) ? (m_last + 1) % 3 : 0;
            for (int k = 0; k < 3; k++) begin
                c = (start + k) % 3;
                if (!found && rq[c]) begin
                    w_s = c; found = 1'b1;
                end
            end
        end
    endtask

    task automatic model_update();
        if (!rst_n) begin
            mdl_mv = 1'b0; mdl_pld = '0; mdl_src = 0; m_last = 2; m_cnt = 0;
            for (int i = 0; i < 3; i++) mdl_g[i] = '0;
        end else begin
            if (!mdl_mv || bus.m_ready) mdl_mv = g_s;
            if (g_s) begin
                mdl_pld = pld_of(w_s);
                mdl_src = w_s;
                if (keep_s || (arb_mode != 2'd2 && w_s == m_last))
                    m_cnt = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
                else
                    m_cnt = 1;
                m_last = w_s;
            end
`ifdef AXI_ARB_STATS_EN
            if (stats_clr) begin
                for (int i = 0; i < 3; i++) mdl_g[i] = '0;
            end else if (g_s) begin
                mdl_g[w_s] = mdl_g[w_s] + 32'd1;
            end
`endif
        end
    endtask

    task automatic pre_edge();
        #1;
        model_decide();
    endtask

    task automatic post_edge();
        @(posedge clk);
        model_update();
        #1;
    endtask

    function automatic logic [63:0] tbl_pld(int c);
        return 64'hA5A5_0000_0000_1000 + 64'(c);
    endfunction

    typedef struct {
        bit         rst;
        bit         en;
        logic [1:0] mode;
        logic [15:0] w1;
        logic [2:0] sv;
        bit         mr;
        logic [2:0] rdy;
        bit         mv;
        int         src;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit rst, bit en, logic [1:0] mode, logic [15:0] w1, logic [2:0] sv,
                                bit mr, logic [2:0] rdy, bit mv, int src);
        vec_t v;
        v.rst = rst; v.en = en; v.mode = mode; v.w1 = w1; v.sv = sv;
        v.mr = mr; v.rdy = rdy; v.mv = mv; v.src = src;
        vecs.push_back(v);
    endfunction

    function automatic void add_rst();
        add(1'b1, 1'b1, 2'd1, 16'd1, 3'b000, 1'b1, 3'b000, 1'b0, 0);
    endfunction

    function automatic void add_seq(logic [1:0] mode, logic [15:0] w1, logic [2:0] sv, int n0, int n1,
                                    int n2, int n3, int n4, int n5, int cnt);
        int s [6];
        s[0] = n0; s[1] = n1; s[2] = n2; s[3] = n3; s[4] = n4; s[5] = n5;
        for (int i = 0; i < cnt; i++) begin
            logic [2:0] one;
            one = 3'b001 << s[i];
            add(1'b0, 1'b1, mode, w1, sv, 1'b1, one, 1'b1, s[i]);
        end
    endfunction

    initial begin
        vec_t v;
        rst_n = 1'b0; arb_en = 1'b1; arb_mode = 2'd0;
        weight0 = 16'd3; weight1 = 16'd1; weight2 = 16'd2;
        bus.s_valid = '0; bus.m_ready = 1'b1;
        bus.s_pld0 = tbl_pld(0); bus.s_pld1 = tbl_pld(1); bus.s_pld2 = tbl_pld(2);
`ifdef AXI_ARB_STATS_EN
        stats_clr = 1'b0;
`endif

        add_rst(); add_rst();
        // arb_en=0: only ch0 is ever granted
        for (int i = 0; i < 10; i++) add(1'b0, 1'b0, 2'd1, 16'd1, 3'b111, 1'b1, 3'b001, 1'b1, 0);
        // fixed priority: ch1 until ch0 appears, ch2 starves
        add_rst();
        add_seq(2'd0, 16'd1, 3'b110, 1, 1, 1, 0, 0, 0, 3);
        add_seq(2'd0, 16'd1, 3'b111, 0, 0, 0, 0, 0, 0, 3);
        // round robin, then ch1 dropped, then idle
        add_rst();
        add_seq(2'd1, 16'd1, 3'b111, 0, 1, 2, 0, 1, 2, 6);
        add_seq(2'd1, 16'd1, 3'b101, 0, 2, 0, 2, 0, 0, 4);
        add(1'b0, 1'b1, 2'd1, 16'd1, 3'b000, 1'b1, 3'b000, 1'b0, 2);
        // weighted RR 3/1/2 and 3/0/2
        for (int p = 0; p < 2; p++) begin
            logic [15:0] w1;
            w1 = (p == 0) ? 16'd1 : 16'd0;
            add_rst();
            add_seq(2'd2, w1, 3'b111, 0, 0, 0, 1, 2, 2, 6);
            add_seq(2'd2, w1, 3'b111, 0, 0, 0, 1, 0, 0, 4);
        end
        // lone requester keeps the grant past its weight
        add_rst();
        add_seq(2'd2, 16'd1, 3'b010, 1, 1, 1, 1, 0, 0, 4);
        // backpressure: stall holds src, RR resumes at the right place
        add_rst();
        add_seq(2'd1, 16'd1, 3'b111, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) add(1'b0, 1'b1, 2'd1, 16'd1, 3'b111, 1'b0, 3'b000, 1'b1, 0);
        add_seq(2'd1, 16'd1, 3'b111, 1, 2, 0, 0, 0, 0, 3);
        // reset while a transfer is pending
        add_rst();
        add_seq(2'd1, 16'd1, 3'b111, 0, 1, 0, 0, 0, 0, 2);
        add(1'b0, 1'b1, 2'd1, 16'd1, 3'b111, 1'b0, 3'b000, 1'b1, 1);
        add(1'b1, 1'b1, 2'd1, 16'd1, 3'b111, 1'b0, 3'b000, 1'b0, 0);
        add_seq(2'd1, 16'd1, 3'b111, 0, 1, 0, 0, 0, 0, 2);

        foreach (vecs[i]) begin
            v = vecs[i];
            rst_n = !v.rst; arb_en = v.en; arb_mode = v.mode; weight1 = v.w1;
            bus.s_valid = v.sv; bus.m_ready = v.mr;
            pre_edge();
            check($sformatf("tbl%0d_s_ready", i), 64'(bus.s_ready), 64'(v.rdy));
            post_edge();
            check($sformatf("tbl%0d_m_valid", i), 64'(bus.m_valid), 64'(v.mv));
            check($sformatf("tbl%0d_m_src", i), 64'(bus.m_src), 64'(v.src));
            if (v.rst) check($sformatf("tbl%0d_m_pld_rst", i), bus.m_pld, 64'd0);
            else if (v.mv) check($sformatf("tbl%0d_m_pld", i), bus.m_pld, tbl_pld(v.src));
`ifdef AXI_ARB_STATS_EN
            if (v.rst) begin
                check($sformatf("tbl%0d_gnt0", i), 64'(gnt_cnt0), 64'd0);
                check($sformatf("tbl%0d_gnt1", i), 64'(gnt_cnt1), 64'd0);
                check($sformatf("tbl%0d_gnt2", i), 64'(gnt_cnt2), 64'd0);
            end
`endif
        end

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst_n = (n < 2) ? 1'b0 : ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 31) == 0) begin
                arb_en   = 1'($urandom);
                arb_mode = 2'($urandom);
                weight0  = 16'($urandom_range(0, 3));
                weight1  = 16'($urandom_range(0, 3));
                weight2  = 16'($urandom_range(0, 3));
            end
            bus.s_valid = 3'($urandom);
            bus.m_ready = ($urandom_range(0, 3) != 0);
            bus.s_pld0  = {$urandom, $urandom};
            bus.s_pld1  = {$urandom, $urandom};
            bus.s_pld2  = {$urandom, $urandom};
`ifdef AXI_ARB_STATS_EN
            stats_clr   = ($urandom_range(0, 49) == 0);
`endif
            pre_edge();
            check($sformatf("rnd%0d_s_ready", n), 64'(bus.s_ready), g_s ? 64'(3'b001 << w_s) : 64'd0);
            post_edge();
            check($sformatf("rnd%0d_m_valid", n), 64'(bus.m_valid), 64'(mdl_mv));
            check($sformatf("rnd%0d_m_src", n), 64'(bus.m_src), 64'(mdl_src));
            check($sformatf("rnd%0d_m_pld", n), bus.m_pld, mdl_pld);
`ifdef AXI_ARB_STATS_EN
            check($sformatf("rnd%0d_gnt0", n), 64'(gnt_cnt0), 64'(mdl_g[0]));
            check($sformatf("rnd%0d_gnt1", n), 64'(gnt_cnt1), 64'(mdl_g[1]));
            check($sformatf("rnd%0d_gnt2", n), 64'(gnt_cnt2), 64'(mdl_g[2]));
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
